// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite crossbar types: response codes, FSM state encodings, slave select.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_WAIT,
    RD_ERR
  } rd_state_t;

  typedef enum logic [2:0] {
    WR_IDLE,
    WR_DATA,
    WR_RESP,
    WR_ERR_DATA,
    WR_ERR_RESP
  } wr_state_t;

  typedef enum logic [1:0] {
    SEL_S0   = 2'd0,
    SEL_S1   = 2'd1,
    SEL_S2   = 2'd2,
    SEL_NONE = 2'd3
  } sel_t;

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite channel bundle; master drives requests, slave drives responses.
interface axi_lite_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, wdata, wmask, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wmask, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_addr_decode.sv
// Address to slave-select decode; lower slave index wins on overlapping windows.
module axi_lite_addr_decode
  import axi_lite_pkg::*;
#(
  parameter logic [31:0] S0_BASE = 32'h8000_0000,
  parameter logic [31:0] S0_MASK = 32'hF800_0000,
  parameter logic [31:0] S1_BASE = 32'h1000_0000,
  parameter logic [31:0] S1_MASK = 32'hFFFF_F000,
  parameter logic [31:0] S2_BASE = 32'h0200_0000,
  parameter logic [31:0] S2_MASK = 32'hFFFF_0000
) (
  input  logic [31:0] i_addr,
  output sel_t        o_sel
);

  // Priority match against the three base/mask windows
  always_comb begin
    if ((i_addr & S0_MASK) == S0_BASE)      o_sel = SEL_S0;
    else if ((i_addr & S1_MASK) == S1_BASE) o_sel = SEL_S1;
    else if ((i_addr & S2_MASK) == S2_BASE) o_sel = SEL_S2;
    else                                    o_sel = SEL_NONE;
  end

endmodule

// File: rtl/axi_lite_xbar_1x3.sv
// 1 master to 3 slave AXI4-Lite crossbar with local DECERR completion for unmapped addresses.
module axi_lite_xbar_1x3
  import axi_lite_pkg::*;
#(
  parameter logic [31:0] S0_BASE = 32'h8000_0000,
  parameter logic [31:0] S0_MASK = 32'hF800_0000,
  parameter logic [31:0] S1_BASE = 32'h1000_0000,
  parameter logic [31:0] S1_MASK = 32'hFFFF_F000,
  parameter logic [31:0] S2_BASE = 32'h0200_0000,
  parameter logic [31:0] S2_MASK = 32'hFFFF_0000
) (
  input logic         clk,
  input logic         reset,
  axi_lite_if.slave   m,
  axi_lite_if.master  s0,
  axi_lite_if.master  s1,
  axi_lite_if.master  s2
);

  rd_state_t r_rd_state;
  wr_state_t r_wr_state;
  sel_t      r_rd_sel;
  sel_t      r_wr_sel;
  sel_t      w_ar_sel;
  sel_t      w_aw_sel;

  // Slave inputs gathered into 4-entry arrays; entry 3 (SEL_NONE) reads as idle
  logic [3:0]  w_s_arready, w_s_rvalid, w_s_awready, w_s_wready, w_s_bvalid;
  logic [31:0] w_s_rdata [4];
  logic [1:0]  w_s_rresp [4];
  logic [1:0]  w_s_bresp [4];

  logic [2:0]  w_s_arvalid, w_s_rready, w_s_awvalid, w_s_wvalid, w_s_bready;
  logic        w_m_arready, w_m_rvalid, w_m_awready, w_m_wready, w_m_bvalid;
  logic [31:0] w_m_rdata;
  logic [1:0]  w_m_rresp, w_m_bresp;

  axi_lite_addr_decode #(
    .S0_BASE(S0_BASE), .S0_MASK(S0_MASK),
    .S1_BASE(S1_BASE), .S1_MASK(S1_MASK),
    .S2_BASE(S2_BASE), .S2_MASK(S2_MASK)
  ) u_ar_decode (
    .i_addr (m.araddr),
    .o_sel  (w_ar_sel)
  );

  axi_lite_addr_decode #(
    .S0_BASE(S0_BASE), .S0_MASK(S0_MASK),
    .S1_BASE(S1_BASE), .S1_MASK(S1_MASK),
    .S2_BASE(S2_BASE), .S2_MASK(S2_MASK)
  ) u_aw_decode (
    .i_addr (m.awaddr),
    .o_sel  (w_aw_sel)
  );

  assign w_s_arready = {1'b0, s2.arready, s1.arready, s0.arready};
  assign w_s_rvalid  = {1'b0, s2.rvalid,  s1.rvalid,  s0.rvalid};
  assign w_s_awready = {1'b0, s2.awready, s1.awready, s0.awready};
  assign w_s_wready  = {1'b0, s2.wready,  s1.wready,  s0.wready};
  assign w_s_bvalid  = {1'b0, s2.bvalid,  s1.bvalid,  s0.bvalid};
  assign w_s_rdata   = '{s0.rdata, s1.rdata, s2.rdata, 32'd0};
  assign w_s_rresp   = '{s0.rresp, s1.rresp, s2.rresp, 2'd0};
  assign w_s_bresp   = '{s0.bresp, s1.bresp, s2.bresp, 2'd0};

  assign m.arready = w_m_arready;
  assign m.rvalid  = w_m_rvalid;
  assign m.rdata   = w_m_rdata;
  assign m.rresp   = w_m_rresp;
  assign m.awready = w_m_awready;
  assign m.wready  = w_m_wready;
  assign m.bvalid  = w_m_bvalid;
  assign m.bresp   = w_m_bresp;

  assign s0.araddr = m.araddr;  assign s1.araddr = m.araddr;  assign s2.araddr = m.araddr;
  assign s0.awaddr = m.awaddr;  assign s1.awaddr = m.awaddr;  assign s2.awaddr = m.awaddr;
  assign s0.wdata  = m.wdata;   assign s1.wdata  = m.wdata;   assign s2.wdata  = m.wdata;
  assign s0.wmask  = m.wmask;   assign s1.wmask  = m.wmask;   assign s2.wmask  = m.wmask;
  assign s0.arvalid = w_s_arvalid[0]; assign s1.arvalid = w_s_arvalid[1]; assign s2.arvalid = w_s_arvalid[2];
  assign s0.rready  = w_s_rready[0];  assign s1.rready  = w_s_rready[1];  assign s2.rready  = w_s_rready[2];
  assign s0.awvalid = w_s_awvalid[0]; assign s1.awvalid = w_s_awvalid[1]; assign s2.awvalid = w_s_awvalid[2];
  assign s0.wvalid  = w_s_wvalid[0];  assign s1.wvalid  = w_s_wvalid[1];  assign s2.wvalid  = w_s_wvalid[2];
  assign s0.bready  = w_s_bready[0];  assign s1.bready  = w_s_bready[1];  assign s2.bready  = w_s_bready[2];

  // Read-path routing from the current read state; all handshakes squashed in reset
  always_comb begin
    w_s_arvalid = '0;
    w_s_rready  = '0;
    w_m_arready = 1'b0;
    w_m_rvalid  = 1'b0;
    w_m_rdata   = '0;
    w_m_rresp   = RESP_OKAY;
    case (r_rd_state)
      RD_IDLE: begin
        w_m_arready = (w_ar_sel == SEL_NONE) ? 1'b1 : w_s_arready[w_ar_sel];
        for (int unsigned k = 0; k < 3; k++)
          w_s_arvalid[k] = (w_ar_sel == 2'(k)) && m.arvalid;
      end
      RD_WAIT: begin
        w_m_rvalid = w_s_rvalid[r_rd_sel];
        w_m_rdata  = w_s_rdata[r_rd_sel];
        w_m_rresp  = w_s_rresp[r_rd_sel];
        for (int unsigned k = 0; k < 3; k++)
          w_s_rready[k] = (r_rd_sel == 2'(k)) && m.rready;
      end
      RD_ERR: begin
        w_m_rvalid = 1'b1;
        w_m_rresp  = RESP_DECERR;
      end
      default: ;
    endcase
    if (reset) begin
      w_s_arvalid = '0;
      w_s_rready  = '0;
      w_m_arready = 1'b0;
      w_m_rvalid  = 1'b0;
    end
  end

  // Write-path routing; W is held off in WR_IDLE so it can never overtake AW
  always_comb begin
    w_s_awvalid = '0;
    w_s_wvalid  = '0;
    w_s_bready  = '0;
    w_m_awready = 1'b0;
    w_m_wready  = 1'b0;
    w_m_bvalid  = 1'b0;
    w_m_bresp   = RESP_OKAY;
    case (r_wr_state)
      WR_IDLE: begin
        w_m_awready = (w_aw_sel == SEL_NONE) ? 1'b1 : w_s_awready[w_aw_sel];
        for (int unsigned k = 0; k < 3; k++)
          w_s_awvalid[k] = (w_aw_sel == 2'(k)) && m.awvalid;
      end
      WR_DATA: begin
        w_m_wready = w_s_wready[r_wr_sel];
        for (int unsigned k = 0; k < 3; k++)
          w_s_wvalid[k] = (r_wr_sel == 2'(k)) && m.wvalid;
      end
      WR_RESP: begin
        w_m_bvalid = w_s_bvalid[r_wr_sel];
        w_m_bresp  = w_s_bresp[r_wr_sel];
        for (int unsigned k = 0; k < 3; k++)
          w_s_bready[k] = (r_wr_sel == 2'(k)) && m.bready;
      end
      WR_ERR_DATA: w_m_wready = 1'b1;
      WR_ERR_RESP: begin
        w_m_bvalid = 1'b1;
        w_m_bresp  = RESP_DECERR;
      end
      default: ;
    endcase
    if (reset) begin
      w_s_awvalid = '0;
      w_s_wvalid  = '0;
      w_s_bready  = '0;
      w_m_awready = 1'b0;
      w_m_wready  = 1'b0;
      w_m_bvalid  = 1'b0;
    end
  end

  // Read FSM: latch target on AR handshake, release on R handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_state <= RD_IDLE;
      r_rd_sel   <= SEL_S0;
    end else begin
      case (r_rd_state)
        RD_IDLE:
          if (m.arvalid && w_m_arready) begin
            if (w_ar_sel == SEL_NONE) begin
              r_rd_state <= RD_ERR;
            end else begin
              r_rd_sel   <= w_ar_sel;
              r_rd_state <= RD_WAIT;
            end
          end
        RD_WAIT: if (w_m_rvalid && m.rready) r_rd_state <= RD_IDLE;
        RD_ERR:  if (m.rready)               r_rd_state <= RD_IDLE;
        default: r_rd_state <= RD_IDLE;
      endcase
    end
  end

  // Write FSM: AW, then W, then B, each routed to the latched target
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_state <= WR_IDLE;
      r_wr_sel   <= SEL_S0;
    end else begin
      case (r_wr_state)
        WR_IDLE:
          if (m.awvalid && w_m_awready) begin
            if (w_aw_sel == SEL_NONE) begin
              r_wr_state <= WR_ERR_DATA;
            end else begin
              r_wr_sel   <= w_aw_sel;
              r_wr_state <= WR_DATA;
            end
          end
        WR_DATA:     if (m.wvalid && w_m_wready) r_wr_state <= WR_RESP;
        WR_RESP:     if (w_m_bvalid && m.bready) r_wr_state <= WR_IDLE;
        WR_ERR_DATA: if (m.wvalid)               r_wr_state <= WR_ERR_RESP;
        WR_ERR_RESP: if (m.bready)               r_wr_state <= WR_IDLE;
        default:     r_wr_state <= WR_IDLE;
      endcase
    end
  end

endmodule
